cu_sequencer: RTL
=================

# cu_sequencer

Program sequencer for `computeUnit_0`. It buffers a short program of instruction/operand byte pairs, then replays that program into the compute unit through a valid/ready issue port. Replay can optionally repeat a number of times, and the host can abort it. The block sits between the chip-level pin decode and the compute unit's `ui_in`/`uio_in` inputs.

## Interface
Parameters:
- `DEPTH`, 8: number of program entries.
- `PC_W`, 3: pointer width; equals log2(DEPTH).
- `REPEAT_W`, 4: width of the repeat count.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: low freezes every register; no handshake completes.
- `load_valid` in 1, `load_ready` out 1: program-write handshake.
- `load_instr` in 8, `load_operand` in 8: entry payload, format as `ui_in`/`uio_in`.
- `clear` in 1: empties the program (IDLE only).
- `start` in 1: begins replay (IDLE only).
- `repeat_cnt` in REPEAT_W: extra passes; sampled with `start`.
- `abort` in 1: kills replay (RUN only).
- `issue_valid` out 1, `issue_ready` in 1: issue handshake.
- `issue_instr` out 8, `issue_operand` out 8: entry at current pc.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on completion.
- `count` out PC_W+1: number of loaded entries.

## Operation
- States:
  - IDLE: accepts loads, `clear` and `start`.
  - RUN: issues entries; pc 0..count-1; passes = repeat_cnt+1.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Load rules:
  - `load_ready` = ena & IDLE & (count<DEPTH).
  - On an accepted load, the entry is written at index count and count increments.
  - When count reaches DEPTH, `load_ready` drops and further loads are dropped.
- `clear` in IDLE sets count to 0; memory contents are don't-care. `clear` and `start` in the same cycle: clear wins and start is ignored.
- `start` with `load_valid` accepted in the same cycle: the new entry is included, so the run length is count+1.
- `start` with count==0 (after any same-cycle load) is ignored and the block stays in IDLE.
- Issue rules in RUN:
  - `issue_valid`=1, payload = mem[pc].
  - A transfer occurs when ena & valid & ready.
  - The payload is held stable until transferred.
  - On transfer: if pc<count-1, pc++.
  - On transfer with pc==count-1: if passes remain, pc=0 and the remaining-repeat counter decrements; otherwise go to DONE.
- `abort` in RUN: next state IDLE, `issue_valid` low from the next cycle. A transfer in the abort cycle still counts. The program is retained. `abort` outside RUN is ignored.
- In IDLE and DONE, `issue_valid`=0.
- The program persists across runs, so `start` replays it.
- `issue_*`, `busy`, `done` and `load_ready` have no combinational path from `issue_ready` or `start`.

## Timing
- Reset values:
  - state IDLE, count 0, pc 0, repeat 0.
  - `issue_valid`, `busy`, `done` 0; `issue_instr`/`issue_operand` 0x00; `load_ready` per rule above.
- Reset mid-RUN returns to IDLE next edge and clears count.
- `start` sampled at edge E: `busy`/`issue_valid` high in cycle E+1.
- With `issue_ready` held high, entries issue back to back at 1 per cycle, with no bubble at pass wrap.
- Last transfer at edge L: `done` high in cycle L+1, IDLE at L+2.
- N entries, R repeats, ready held: `busy` lasts N*(R+1) cycles.
- `ena` low: state, pc and counters hold and outputs stay stable.

## Configuration
- `CU_SEQ_NOP_SKIP_EN` defined:
  - An entry whose `load_instr[7:4]`==4'h0 (NOP) is never issued.
  - In RUN on such an entry, `issue_valid`=0 and pc advances (or wraps/finishes) that cycle without waiting for ready, costing one cycle.
- Undefined: NOP entries are issued like any other entry.

## Structure
- Package `cu_seq_pkg`:
  - state encoding (IDLE=0, RUN=1, DONE=2);
  - opcode constants OP_NOP=4'h0, OP_LOAD=4'h9, OP_ADD=4'hA;
  - default DEPTH/REPEAT_W.
- Sub-module `cu_seq_progmem`: DEPTH x 16 register file, one synchronous write port, one asynchronous read port at pc, no reset on array.

## Test plan
- Load (0x90,0x48),(0x91,0x81),(0xA2,0x01), start with repeat 0, ready=1 -> three issues in consecutive cycles in that order; `done` on the cycle after the third; `busy` for 3 cycles.
- Same program, repeat_cnt=2 -> 9 issues, sequence 0x90,0x91,0xA2 ×3, no bubbles, one `done` pulse.
- Ready toggled 1,0,0,1,... -> payload held stable while ready=0; no entry skipped or duplicated.
- 8 loads, then a 9th `load_valid` -> `load_ready`=0; count=8; 9th dropped; `clear` gives count=0.
- `abort` asserted after the 2nd transfer of 3 -> `issue_valid` low next cycle; no `done`; count still 3; restart issues from 0x90.
- With `CU_SEQ_NOP_SKIP_EN` and program (0x90,0x05),(0x00,0x00),(0xA2,0x01) -> two issues with a one-cycle gap; `busy` for 3 cycles. Without the macro: three issues.

Source files
------------

// File: rtl/cu_seq_pkg.sv
// Shared types and constants for the compute-unit program sequencer.
package cu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;

    localparam int DEF_DEPTH    = 8;
    localparam int DEF_PC_W     = 3;
    localparam int DEF_REPEAT_W = 4;

    function automatic logic is_nop(input logic [7:0] instr);
        return instr[7:4] == OP_NOP;
    endfunction

endpackage

// File: rtl/cu_seq_progmem.sv
// Program store: DEPTH x 16 register file, synchronous write, asynchronous read.
module cu_seq_progmem #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 3
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PC_W-1:0] waddr,
    input  logic [15:0]     wdata,
    input  logic [PC_W-1:0] raddr,
    output logic [15:0]     rdata
);

    logic [15:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/cu_sequencer.sv
// Program sequencer: buffers instr/operand pairs and replays them over a valid/ready port.
// Optional feature macro CU_SEQ_NOP_SKIP_EN: NOP entries (instr[7:4]==0) are skipped, not issued.
module cu_sequencer
    import cu_seq_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PC_W     = DEF_PC_W,
    parameter int REPEAT_W = DEF_REPEAT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [7:0]          load_instr,
    input  logic [7:0]          load_operand,
    input  logic                clear,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic                abort,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [7:0]          issue_instr,
    output logic [7:0]          issue_operand,
    output logic                busy,
    output logic                done,
    output logic [PC_W:0]       count
);

    localparam logic [PC_W:0] FULL = (PC_W+1)'(DEPTH);

    state_t              state_reg;
    logic [PC_W:0]       count_reg;
    logic [PC_W-1:0]     pc_reg;
    logic [REPEAT_W-1:0] rep_reg;

    logic [15:0]   rd_data;
    logic          load_fire;
    logic          issue_fire;
    logic          nop_here;
    logic          advance;
    logic          last_entry;
    logic [PC_W:0] count_next;

    cu_seq_progmem #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_progmem (
        .clk   (clk),
        .we    (load_fire),
        .waddr (count_reg[PC_W-1:0]),
        .wdata ({load_instr, load_operand}),
        .raddr (pc_reg),
        .rdata (rd_data)
    );

    assign load_ready = ena && (state_reg == ST_IDLE) && (count_reg < FULL);
    assign load_fire  = load_valid && load_ready;
    assign count_next = count_reg + (PC_W+1)'(load_fire);

`ifdef CU_SEQ_NOP_SKIP_EN
    assign nop_here = (state_reg == ST_RUN) && is_nop(rd_data[15:8]);
`else
    assign nop_here = 1'b0;
`endif

    // All issue-side outputs decode only registered state, never issue_ready or start.
    assign busy          = (state_reg == ST_RUN);
    assign done          = (state_reg == ST_DONE);
    assign issue_valid   = busy && !nop_here;
    assign issue_instr   = busy ? rd_data[15:8] : 8'h00;
    assign issue_operand = busy ? rd_data[7:0]  : 8'h00;
    assign count         = count_reg;

    assign issue_fire = ena && issue_valid && issue_ready;
    assign advance    = issue_fire || (ena && nop_here);
    assign last_entry = ({1'b0, pc_reg} == (count_reg - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            pc_reg    <= '0;
            rep_reg   <= '0;
        end else if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    // clear outranks both a same-cycle load and start
                    if (clear) begin
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_next;
                        if (start && (count_next != '0)) begin
                            state_reg <= ST_RUN;
                            pc_reg    <= '0;
                            rep_reg   <= repeat_cnt;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        pc_reg    <= '0;
                    end else if (advance) begin
                        if (!last_entry) begin
                            pc_reg <= pc_reg + 1'b1;
                        end else if (rep_reg != '0) begin
                            pc_reg  <= '0;
                            rep_reg <= rep_reg - 1'b1;
                        end else begin
                            pc_reg    <= '0;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
